// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   IF stage of the pipelined MIPS core. Owns the program counter, presents
//   the word address to the instruction memory, and captures the returned
//   word into the IF/ID pipeline register. Handles stall, flush, redirect
//   (taken branch/jump) and halt, and counts the real instructions it has
//   handed to ID.
//
// Ports
//   clk          in   1   single clock, all state changes on the rising edge
//   reset        in   1   synchronous, active-high
//   stall        in   1   hold PC and IF/ID
//   flush        in   1   replace IF/ID with a bubble on the next edge
//   redirect     in   1   load redirect_pc into PC
//   redirect_pc  in   32  target byte address (low two bits dropped)
//   halt         in   1   stop fetching until reset
//   imem_inst    in   32  instruction word read combinationally at imem_pc
//   imem_pc      out  30  word address, PC[31:2]
//   id_inst      out  32  IF/ID instruction
//   id_pc4       out  32  IF/ID PC+4 of that instruction
//   id_valid     out  1   IF/ID holds a real instruction
//   inst_count   out  32  valid instructions loaded into IF/ID since reset
//   misalign_err out  1   sticky flag: a misaligned redirect target was taken
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   input  logic [31:0] imem_inst,
   output logic [29:0] imem_pc,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic [31:0] inst_count,
   output logic        misalign_err
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_next_seq;

   // Sequential successor of the PC; wraps naturally at 2^32.
   assign pc_next_seq = pc + 32'd4;

   // The memory is addressed by word, so the two always-zero byte bits are dropped.
   assign imem_pc = pc[31:2];

   // Whole stage state: RUN/HALT control plus PC and IF/ID register.
   // In RUN the priority is redirect > stall > flush > normal fetch. A redirect
   // beats a stall because the word currently being fetched is on the wrong
   // path anyway. Halt beats everything, including a same-cycle redirect, and
   // the only way out of HALT is reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         pc           <= RESET_PC;
         id_inst      <= NOP_WORD;
         id_pc4       <= 32'd0;
         id_valid     <= 1'b0;
         inst_count   <= 32'd0;
         misalign_err <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (halt) begin
                  state    <= HALT;
                  id_inst  <= NOP_WORD;
                  id_pc4   <= 32'd0;
                  id_valid <= 1'b0;
               end else if (redirect) begin
                  pc       <= {redirect_pc[31:2], 2'b00};
                  id_inst  <= NOP_WORD;
                  id_pc4   <= 32'd0;
                  id_valid <= 1'b0;
                  if (redirect_pc[1:0] != 2'b00) begin
                     misalign_err <= 1'b1;
                  end
               end else if (stall) begin
                  pc       <= pc;
               end else if (flush) begin
                  pc       <= pc_next_seq;
                  id_inst  <= NOP_WORD;
                  id_pc4   <= 32'd0;
                  id_valid <= 1'b0;
               end else begin
                  pc         <= pc_next_seq;
                  id_inst    <= imem_inst;
                  id_pc4     <= pc_next_seq;
                  id_valid   <= 1'b1;
                  inst_count <= inst_count + 32'd1;
               end
            end
            HALT: begin
               id_inst  <= NOP_WORD;
               id_pc4   <= 32'd0;
               id_valid <= 1'b0;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed-vector bench for fetch_stage. Each vector drives the inputs for
//   one clock edge and queues the outputs expected after that edge; a
//   separate monitor pops the queue after every edge and compares.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   typedef struct {
      logic [29:0] imem;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] cnt;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] imem_inst;
   logic [29:0] imem_pc;
   logic [31:0] id_inst;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic [31:0] inst_count;
   logic        misalign_err;

   exp_t exp_q[$];
   int   total_checks;
   int   bad_checks;

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .halt         (halt),
      .imem_inst    (imem_inst),
      .imem_pc      (imem_pc),
      .id_inst      (id_inst),
      .id_pc4       (id_pc4),
      .id_valid     (id_valid),
      .inst_count   (inst_count),
      .misalign_err (misalign_err)
   );

   // Free-running clock, first rising edge at 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory: each word is a distinct pattern of its own address.
   function automatic logic [31:0] memWord(input logic [29:0] a);
      return {2'b01, a} ^ 32'h1357_9BDF;
   endfunction

   assign imem_inst = memWord(imem_pc);

   // The word held in IF/ID follows from its PC+4; bubbles hold the NOP word.
   function automatic logic [31:0] expInst(input logic [31:0] pc4, input logic valid);
      logic [31:0] pc;
      pc = pc4 - 32'd4;
      return valid ? memWord(pc[31:2]) : 32'h0000_0000;
   endfunction

   task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req);
      total_checks++;
      if (act !== req) begin
         bad_checks++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compareField("imem_pc",      {2'b00, imem_pc}, {2'b00, e.imem});
      compareField("id_inst",      id_inst,          e.inst);
      compareField("id_pc4",       id_pc4,           e.pc4);
      compareField("id_valid",     {31'd0, id_valid}, {31'd0, e.valid});
      compareField("inst_count",   inst_count,       e.cnt);
      compareField("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
   endtask

   // Drive one edge worth of inputs, queue the expected post-edge outputs,
   // then advance just past the edge.
   task automatic applyStimulus(
      input logic        r,
      input logic        st,
      input logic        fl,
      input logic        rd,
      input logic [31:0] rpc,
      input logic        hl,
      input logic [29:0] e_imem,
      input logic [31:0] e_pc4,
      input logic        e_valid,
      input logic [31:0] e_cnt,
      input logic        e_mis
   );
      exp_t e;
      reset       = r;
      stall       = st;
      flush       = fl;
      redirect    = rd;
      redirect_pc = rpc;
      halt        = hl;
      e.imem  = e_imem;
      e.pc4   = e_pc4;
      e.valid = e_valid;
      e.inst  = expInst(e_pc4, e_valid);
      e.cnt   = e_cnt;
      e.mis   = e_mis;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: after every edge, compare against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      int wait_cycles;
      total_checks = 0;
      bad_checks   = 0;

      // Reset
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 30'h0010_0000, 32'h0, 0, 0, 0);

      // Free fetch from the reset PC
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0001, 32'h0040_0004, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0002, 32'h0040_0008, 1, 2, 0);

      // Stall two cycles with PC at 0x00400008, then resume with no lost word
      applyStimulus(0, 1, 0, 0, 32'h0, 0, 30'h0010_0002, 32'h0040_0008, 1, 2, 0);
      applyStimulus(0, 1, 1, 0, 32'h0, 0, 30'h0010_0002, 32'h0040_0008, 1, 2, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0003, 32'h0040_000C, 1, 3, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0004, 32'h0040_0010, 1, 4, 0);

      // Redirect wins over a same-cycle stall
      applyStimulus(0, 1, 0, 1, 32'h0040_0040, 0, 30'h0010_0010, 32'h0, 0, 4, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0011, 32'h0040_0044, 1, 5, 0);

      // Misaligned redirect: target truncated, sticky error
      applyStimulus(0, 0, 0, 1, 32'h0040_0042, 0, 30'h0010_0010, 32'h0, 0, 5, 1);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0011, 32'h0040_0044, 1, 6, 1);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0012, 32'h0040_0048, 1, 7, 1);

      // Halt together with redirect: halt wins, everything frozen
      applyStimulus(0, 0, 0, 1, 32'h0040_0080, 1, 30'h0010_0012, 32'h0, 0, 7, 1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, i[0], i[1], i[2], 32'h0040_0100, i[0], 30'h0010_0012, 32'h0, 0, 7, 1);
      end

      // Reset out of HALT clears everything
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 30'h0010_0000, 32'h0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0010_0001, 32'h0040_0004, 1, 1, 0);

      // Redirect to the top word, PC+4 wraps to zero without an error
      applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 30'h3FFF_FFFF, 32'h0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0000_0000, 32'h0000_0000, 1, 2, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0000_0001, 32'h0000_0004, 1, 3, 0);

      // Flush alone advances PC and bubbles IF/ID
      applyStimulus(0, 0, 1, 0, 32'h0, 0, 30'h0000_0002, 32'h0, 0, 3, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 30'h0000_0003, 32'h0000_000C, 1, 4, 0);

      // Stall with flush: stall holds everything
      applyStimulus(0, 1, 1, 0, 32'h0, 0, 30'h0000_0003, 32'h0000_000C, 1, 4, 0);

      reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; halt = 1'b0;

      // Let the monitor drain the queue, bounded
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         #5;
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         total_checks++;
         bad_checks++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
